// File: rtl/lock_pkg.sv
// Shared definitions for the keypad combination lock: mode encoding, keypad map,
// seven-segment table and entry length.
package lock_pkg;

  localparam int DIGITS = 3;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_SET   = 3'd1,
    MODE_CHECK = 3'd2,
    MODE_OPEN  = 3'd3,
    MODE_ALARM = 3'd4
  } mode_e;

  // Keypad layout by {row, col}: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] seg;
    case (h)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/lock_counter.sv
// Free-running modulo-CNT_MAX counter; cnt_end marks the last count of each period.
module counter #(
  parameter int CNT_MAX = 100000,
  parameter int WIDTH   = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic cnt_inc,
  output logic cnt_end
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == WIDTH'(CNT_MAX - 1));
  assign cnt_end  = cnt_inc & w_at_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_cnt <= '0;
    else if (cnt_inc) r_cnt <= w_at_max ? '0 : r_cnt + WIDTH'(1);
  end

endmodule

// File: rtl/lock.sv
// 3-digit keypad combination lock: column scan, key events, set/check modes, fail counter.
// Build option LOCK_LOCKOUT_EN: when defined, ALARM ignores set1/check/sure until rst.
module lock
  import lock_pkg::*;
#(
  parameter int CNT_THRESHOLD = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set1,
  input  logic       check,
  input  logic       sure,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] led_en,
  output logic [6:0] led,
  output logic       led0,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [2:0] o_dbg_mode
);

  localparam logic [2:0] ST_IDLE  = MODE_IDLE;
  localparam logic [2:0] ST_SET   = MODE_SET;
  localparam logic [2:0] ST_CHECK = MODE_CHECK;
  localparam logic [2:0] ST_OPEN  = MODE_OPEN;
  localparam logic [2:0] ST_ALARM = MODE_ALARM;

  logic                  w_tick;
  logic [3:0]            r_col;
  logic [1:0]            w_col_idx, w_row_idx;
  logic                  w_row_hit, w_scan_end, w_res_valid, w_key_evt;
  logic [3:0]            w_res_code;
  logic                  r_found, r_prev_valid;
  logic [3:0]            r_code, r_prev_code;
  logic [2:0]            r_mode, r_pos;
  logic [DIGITS*4-1:0]   r_buf, r_pwd;
  logic [1:0]            r_count, r_fail, w_fail_inc;
  logic                  w_free, w_entry, w_cmd_set, w_cmd_check, w_cmd_sure;

  counter #(.CNT_MAX(CNT_THRESHOLD), .WIDTH(24)) u_tick (
    .clk    (clk),
    .reset  (rst),
    .cnt_inc(1'b1),
    .cnt_end(w_tick)
  );

  always_comb begin
    case (r_col)
      4'b0111: w_col_idx = 2'd0;
      4'b1011: w_col_idx = 2'd1;
      4'b1101: w_col_idx = 2'd2;
      default: w_col_idx = 2'd3;
    endcase
    if      (!row[3]) w_row_idx = 2'd0;
    else if (!row[2]) w_row_idx = 2'd1;
    else if (!row[1]) w_row_idx = 2'd2;
    else              w_row_idx = 2'd3;
  end

  // The scan result includes the last column's sample, taken on the same tick.
  assign w_row_hit   = (row != 4'b1111);
  assign w_scan_end  = w_tick && (r_col == 4'b1110);
  assign w_res_valid = r_found | w_row_hit;
  assign w_res_code  = r_found ? r_code : key_code(w_row_idx, w_col_idx);
  assign w_key_evt   = w_scan_end && w_res_valid &&
                       (!r_prev_valid || (w_res_code != r_prev_code));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= 4'b0111;
      r_pos        <= 3'd0;
      r_found      <= 1'b0;
      r_code       <= 4'h0;
      r_prev_valid <= 1'b0;
      r_prev_code  <= 4'h0;
    end else if (w_tick) begin
      r_col <= {r_col[0], r_col[3:1]};
      r_pos <= r_pos + 3'd1;
      if (w_scan_end) begin
        r_found      <= 1'b0;
        r_prev_valid <= w_res_valid;
        r_prev_code  <= w_res_code;
      end else if (w_row_hit && !r_found) begin
        r_found <= 1'b1;
        r_code  <= key_code(w_row_idx, w_col_idx);
      end
    end
  end

`ifdef LOCK_LOCKOUT_EN
  assign w_free = (r_mode == ST_IDLE) || (r_mode == ST_OPEN);
`else
  assign w_free = (r_mode == ST_IDLE) || (r_mode == ST_OPEN) || (r_mode == ST_ALARM);
`endif

  // Only the highest-priority pulse present counts as the command this cycle.
  assign w_cmd_set   = set1;
  assign w_cmd_check = check & ~set1;
  assign w_cmd_sure  = sure & ~set1 & ~check;
  assign w_entry     = (r_mode == ST_SET) || (r_mode == ST_CHECK);
  assign w_fail_inc  = (r_fail == 2'd3) ? 2'd3 : r_fail + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= ST_IDLE;
      r_buf   <= '0;
      r_count <= 2'd0;
      r_pwd   <= '0;
      r_fail  <= 2'd0;
      led0    <= 1'b0;
      led1    <= 1'b0;
      led2    <= 1'b0;
      led3    <= 1'b0;
    end else if (w_cmd_set && w_free) begin
      r_mode  <= ST_SET;
      r_buf   <= '0;
      r_count <= 2'd0;
      led0    <= 1'b0;
    end else if (w_cmd_check && w_free) begin
      r_mode  <= ST_CHECK;
      r_buf   <= '0;
      r_count <= 2'd0;
      led0    <= 1'b0;
    end else if (w_cmd_sure && (r_mode == ST_SET)) begin
      r_pwd  <= r_buf;
      r_mode <= ST_IDLE;
    end else if (w_cmd_sure && (r_mode == ST_CHECK)) begin
      if (r_buf == r_pwd) begin
        r_mode <= ST_OPEN;
        r_fail <= 2'd0;
        led0   <= 1'b1;
        led1   <= 1'b0;
        led2   <= 1'b0;
        led3   <= 1'b0;
      end else begin
        r_fail <= w_fail_inc;
        r_mode <= (w_fail_inc == 2'd3) ? ST_ALARM : ST_IDLE;
        led1   <= (w_fail_inc >= 2'd1);
        led2   <= (w_fail_inc >= 2'd2);
        led3   <= (w_fail_inc == 2'd3);
      end
    end else if (w_key_evt && w_entry) begin
      r_buf   <= {r_buf[DIGITS*4-5:0], w_res_code};
      r_count <= (r_count == 2'd3) ? 2'd3 : r_count + 2'd1;
    end
  end

  always_comb begin
    led = 7'h7F;
    case (r_pos)
      3'd0:    if (r_count >= 2'd1) led = hex_seg(r_buf[3:0]);
      3'd1:    if (r_count >= 2'd2) led = hex_seg(r_buf[7:4]);
      3'd2:    if (r_count >= 2'd3) led = hex_seg(r_buf[11:8]);
      default: led = 7'h7F;
    endcase
  end

  assign col        = r_col;
  assign led_en     = ~(8'h01 << r_pos);
  assign o_dbg_mode = r_mode;

endmodule

// File: tb/tb_lock.sv
// Directed bench for the keypad lock with a small keypad model driving row from col.
module tb_lock;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst, set1, check, sure;
  logic [3:0] row, col;
  logic [7:0] led_en;
  logic [6:0] led;
  logic       led0, led1, led2, led3;
  logic [2:0] dbg_mode;
  int         tests = 0;
  int         fails = 0;

  logic       key_down = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0;

  // A pressed key pulls its row low only while its column is driven low.
  assign row = (key_down && (col[2'd3 - key_c] == 1'b0)) ? ~(4'b1000 >> key_r) : 4'b1111;

  always #5 clk = ~clk;

  lock #(.CNT_THRESHOLD(5)) dut (
    .clk(clk), .rst(rst), .set1(set1), .check(check), .sure(sure), .row(row),
    .col(col), .led_en(led_en), .led(led), .led0(led0), .led1(led1), .led2(led2),
    .led3(led3), .o_dbg_mode(dbg_mode)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) set1 = 1'b1;
    else if (which == 1) check = 1'b1;
    else sure = 1'b1;
    @(negedge clk);
    set1 = 1'b0; check = 1'b0; sure = 1'b0;
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    case (d)
      4'h1: begin key_r = 2'd0; key_c = 2'd0; end
      4'h2: begin key_r = 2'd0; key_c = 2'd1; end
      4'h3: begin key_r = 2'd0; key_c = 2'd2; end
      4'h4: begin key_r = 2'd1; key_c = 2'd0; end
      default: begin key_r = 2'd3; key_c = 2'd1; end
    endcase
    @(negedge clk); key_down = 1'b1;
    repeat (hold) @(negedge clk);
    key_down = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    press(a, 40); press(b, 40); press(c, 40);
  endtask

  task automatic read_pos(input int p, output logic [6:0] seg, output bit ok);
    logic [7:0] tgt;
    tgt = ~(8'h01 << p);
    ok  = 1'b0;
    seg = 7'h00;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (led_en === tgt) begin ok = 1'b1; seg = led; break; end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4];
    exp_col = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
    rst = 1'b1; set1 = 1'b0; check = 1'b0; sure = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({col, led_en, led, led0, led1, led2, led3, dbg_mode} !== {4'b0111, 8'hFE, 7'h7F, 4'b0000, 3'(MODE_IDLE)}) begin
      fails++;
      $display("FAIL reset_outputs: got col=%b led_en=%h led=%h leds=%b%b%b%b mode=%0d, expected col=0111 led_en=fe led=7f leds=0000 mode=0",
               col, led_en, led, led3, led2, led1, led0, dbg_mode);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (col !== 4'b0111) begin fails++; $display("FAIL tick_early: col=%b expected 0111", col); end
    for (int t = 0; t < 4; t++) begin
      if (t == 0) @(posedge clk); else repeat (5) @(posedge clk);
      #1;
      tests++;
      if (col !== exp_col[t]) begin fails++; $display("FAIL scan_col%0d: col=%b expected %b", t, col, exp_col[t]); end
    end
    tests++;
    if (led_en !== 8'hEF) begin fails++; $display("FAIL scan_pos: led_en=%h expected ef", led_en); end
  endtask

  task automatic test_key_event();
    logic [6:0] seg; bit ok;
    pulse(0);
    tests++;
    if (dbg_mode !== 3'(MODE_SET)) begin fails++; $display("FAIL enter_set: mode=%0d expected %0d", dbg_mode, MODE_SET); end
    press(4'h1, 100);
    read_pos(0, seg, ok);
    tests++;
    if (!ok || seg !== 7'h79) begin fails++; $display("FAIL key1_pos0: seg=%h ok=%0d expected 79", seg, ok); end
    read_pos(1, seg, ok);
    tests++;
    if (!ok || seg !== 7'h7F) begin fails++; $display("FAIL key_no_repeat: seg=%h ok=%0d expected 7f", seg, ok); end
  endtask

  task automatic test_display();
    logic [6:0] seg; bit ok;
    logic [6:0] exp_seg [8];
    exp_seg = '{7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    press(4'h2, 40);
    for (int p = 0; p < 8; p++) begin
      read_pos(p, seg, ok);
      tests++;
      if (!ok || seg !== exp_seg[p]) begin
        fails++; $display("FAIL display_pos%0d: seg=%h ok=%0d expected %h", p, seg, ok, exp_seg[p]);
      end
    end
  endtask

  task automatic test_set_password();
    logic [6:0] seg; bit ok;
    press(4'h3, 40);
    read_pos(2, seg, ok);
    tests++;
    if (!ok || seg !== 7'h79) begin fails++; $display("FAIL oldest_pos2: seg=%h ok=%0d expected 79", seg, ok); end
    read_pos(0, seg, ok);
    tests++;
    if (!ok || seg !== 7'h30) begin fails++; $display("FAIL newest_pos0: seg=%h ok=%0d expected 30", seg, ok); end
    pulse(2);
    tests++;
    if (dbg_mode !== 3'(MODE_IDLE)) begin fails++; $display("FAIL set_sure: mode=%0d expected %0d", dbg_mode, MODE_IDLE); end
  endtask

  task automatic test_check_open();
    pulse(1);
    tests++;
    if (dbg_mode !== 3'(MODE_CHECK)) begin fails++; $display("FAIL enter_check: mode=%0d expected %0d", dbg_mode, MODE_CHECK); end
    enter3(4'h1, 4'h2, 4'h3);
    pulse(2);
    tests++;
    if ({led3, led2, led1, led0, dbg_mode} !== {4'b0001, 3'(MODE_OPEN)}) begin
      fails++; $display("FAIL check_open: leds=%b%b%b%b mode=%0d expected leds=0001 mode=%0d", led3, led2, led1, led0, dbg_mode, MODE_OPEN);
    end
  endtask

  task automatic test_change_password();
    pulse(0);
    tests++;
    if (led0 !== 1'b0 || dbg_mode !== 3'(MODE_SET)) begin
      fails++; $display("FAIL reset_from_open: led0=%b mode=%0d expected led0=0 mode=%0d", led0, dbg_mode, MODE_SET);
    end
    enter3(4'h1, 4'h2, 4'h1);
    pulse(2);
    tests++;
    if (dbg_mode !== 3'(MODE_IDLE)) begin fails++; $display("FAIL change_sure: mode=%0d expected %0d", dbg_mode, MODE_IDLE); end
  endtask

  task automatic test_failures();
    logic [3:0] seq [3][3];
    logic [2:0] exp_leds [3];
    logic [2:0] exp_mode [3];
    seq      = '{'{4'h2, 4'h3, 4'h1}, '{4'h3, 4'h2, 4'h3}, '{4'h2, 4'h1, 4'h3}};
    exp_leds = '{3'b001, 3'b011, 3'b111};
    exp_mode = '{3'(MODE_IDLE), 3'(MODE_IDLE), 3'(MODE_ALARM)};
    for (int k = 0; k < 3; k++) begin
      pulse(1);
      enter3(seq[k][0], seq[k][1], seq[k][2]);
      pulse(2);
      tests++;
      if ({led3, led2, led1} !== exp_leds[k] || dbg_mode !== exp_mode[k] || led0 !== 1'b0) begin
        fails++; $display("FAIL fail%0d: led3..0=%b%b%b%b mode=%0d expected led3..1=%b led0=0 mode=%0d",
                          k + 1, led3, led2, led1, led0, dbg_mode, exp_leds[k], exp_mode[k]);
      end
    end
  endtask

  task automatic test_alarm_config();
`ifdef LOCK_LOCKOUT_EN
    pulse(0);
    pulse(1);
    tests++;
    if (dbg_mode !== 3'(MODE_ALARM) || led3 !== 1'b1) begin
      fails++; $display("FAIL lockout: mode=%0d led3=%b expected mode=%0d led3=1", dbg_mode, led3, MODE_ALARM);
    end
`else
    pulse(1);
    tests++;
    if (dbg_mode !== 3'(MODE_CHECK)) begin fails++; $display("FAIL alarm_as_idle: mode=%0d expected %0d", dbg_mode, MODE_CHECK); end
    enter3(4'h1, 4'h2, 4'h1);
    pulse(2);
    tests++;
    if ({led3, led2, led1, led0, dbg_mode} !== {4'b0001, 3'(MODE_OPEN)}) begin
      fails++; $display("FAIL alarm_clear: leds=%b%b%b%b mode=%0d expected leds=0001 mode=%0d", led3, led2, led1, led0, dbg_mode, MODE_OPEN);
    end
`endif
  endtask

  task automatic test_reset_mid_entry();
    pulse(0);
    press(4'h4, 40);
    key_r = 2'd1; key_c = 2'd0; key_down = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (led_en === 8'hFD) break;
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({col, led_en, led, led0, led1, led2, led3, dbg_mode} !== {4'b0111, 8'hFE, 7'h7F, 4'b0000, 3'(MODE_IDLE)}) begin
      fails++;
      $display("FAIL async_reset: got col=%b led_en=%h led=%h leds=%b%b%b%b mode=%0d, expected col=0111 led_en=fe led=7f leds=0000 mode=0",
               col, led_en, led, led3, led2, led1, led0, dbg_mode);
    end
    key_down = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    pulse(1);
    enter3(4'h0, 4'h0, 4'h0);
    pulse(2);
    tests++;
    if (led0 !== 1'b1 || dbg_mode !== 3'(MODE_OPEN)) begin
      fails++; $display("FAIL password_reset_000: led0=%b mode=%0d expected led0=1 mode=%0d", led0, dbg_mode, MODE_OPEN);
    end
  endtask

  initial begin
    test_reset();
    test_key_event();
    test_display();
    test_set_password();
    test_check_open();
    test_change_password();
    test_failures();
    test_alarm_config();
    test_reset_mid_entry();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
